imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of `Simple_Single_CPU`. It accepts a byte stream (header, payload, checksum) over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them into instruction memory at word-aligned byte addresses and holds the CPU stalled until a checksum-verified load completes. On success it asserts `cpu_run_o`, which gates the CPU's run/reset input.

## Interface
- `ADDR_W`, 8: word-index width; `MAX_WORDS` = 2**`ADDR_W` (256).
- `clk_i`  input  1  clock, rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `start_i`  input  1  restart pulse. Aborts any load and returns to header reception.
- `byte_valid_i`  input  1  source has a byte.
- `byte_data_i`  input  8  byte value.
- `byte_ready_o`  output  1  loader accepts a byte. A transfer occurs on an edge where valid && ready.
- `imem_we_o`  output  1  instruction-memory write strobe, one-cycle pulse.
- `imem_addr_o`  output  32  byte address, always word index × 4.
- `imem_data_o`  output  32  instruction word.
- `cpu_run_o`  output  1  high only in DONE. The CPU is stalled while low.
- `load_err_o`  output  1  high only in ERR.

## Operation
- States: HDR (receive 4-byte word count N), LOAD (receive N payload words), CHK (receive 4-byte checksum), DONE, ERR.
- Byte assembly is big-endian: first byte → bits 31:24, fourth → 7:0. A 2-bit byte counter wraps 3→0 on each completed word.
- HDR: on the 4th byte:
  - N == 0 → CHK.
  - N > `MAX_WORDS` → ERR, with no writes.
  - Otherwise latch N, clear the word index and running checksum, → LOAD.
- LOAD: on each completed word:
  - Issue a write to address index×4.
  - XOR the word into the running checksum and increment the index.
  - When index reaches N → CHK.
- CHK: on the 4th byte, compare with the running checksum (0 when N == 0). Match → DONE; mismatch → ERR.
- DONE and ERR hold until `start_i` or reset; `byte_ready_o` is low in both.
- `start_i` in any state:
  - Next state HDR.
  - Clear the byte counter, partial word, index and checksum.
  - `cpu_run_o` and `load_err_o` go low.
  - Previously written memory is not cleared.
- Simultaneous `start_i` and byte transfer: `start_i` wins and the byte is discarded. Any write pending from an earlier edge still completes.
- A partial word at abort or reset is discarded and never written.
- Widths: N compared as unsigned 32-bit. The index is `ADDR_W`+1 bits so that N == `MAX_WORDS` is representable. Address = {index, 2'b00} zero-extended to 32 bits.

## Timing
- All outputs are registered.
- Reset values: `byte_ready_o`=0, `imem_we_o`=0, `imem_addr_o`=0, `imem_data_o`=0, `cpu_run_o`=0, `load_err_o`=0; state HDR.
- `byte_ready_o` rises on the first rising edge after `rst_i` deasserts. It stays high in HDR/LOAD/CHK, with no bubbles between bytes.
- Write latency: the 4th payload byte is accepted at edge k. `imem_we_o`/addr/data are valid from edge k to edge k+1, and `imem_we_o` is low afterward unless another word completes.
- The source may drop `byte_valid_i` at any cycle. The loader does not advance without a transfer.
- Final checksum byte accepted at edge k:
  - `cpu_run_o` (or `load_err_o`) is high from edge k.
  - `byte_ready_o` is low from edge k.
- `start_i` sampled at edge k: `cpu_run_o`/`load_err_o` are low from edge k, and HDR is accepting bytes from edge k.
- `rst_i` asserted mid-load: all outputs take reset values immediately (asynchronously). No write strobe is generated for the in-flight word.
- Minimum load time for N words: 4×(N+2) transfer cycles.

## Test plan
- Normal load: N=2, words 0x20010005, 0x20020007, checksum 0x00030002.
  - Expect writes (0x0, 0x20010005) then (0x4, 0x20020007), each one-cycle strobe.
  - `cpu_run_o`=1 after the last byte, then `byte_ready_o`=0.
- Bad checksum: same stream with checksum 0x00030003.
  - Both writes still occur.
  - `load_err_o`=1, `cpu_run_o`=0.
  - A following `start_i` clears `load_err_o` and a correct reload reaches DONE.
- Boundaries:
  - N=0 with checksum 0 → DONE with no writes.
  - N=257 → ERR at the 4th header byte with no writes.
  - N=256 → last write at address 0x3FC, then DONE.
- Handshake gaps: random `byte_valid_i` deassertion during an N=3 load → identical writes and checksum outcome as the gap-free run.
- Abort and reset:
  - `start_i` after 2 bytes of payload word 1 → no write for that word. Loader is back in HDR, and a fresh N=1 load succeeds.
  - `rst_i` pulse mid-word → all outputs at reset values and no strobe. `byte_ready_o` returns one edge after release.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles big-endian words from a byte stream,
// writes them into instruction memory and releases the CPU after a checksum-verified load.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_data_o,
   output logic        cpu_run_o,
   output logic        load_err_o
);
   localparam int MAX_WORDS = 2**ADDR_W;

   typedef enum logic [2:0] {HDR, LOAD, CHK, DONE, ERR} state_t;

   state_t            state;
   logic [1:0]        bcnt;
   logic [23:0]       part;
   logic [ADDR_W:0]   n;
   logic [ADDR_W:0]   idx;
   logic [ADDR_W:0]   idx_nxt;
   logic [31:0]       csum;
   logic [31:0]       w;
   logic              xfer;
   logic              busy;

   assign w       = {part, byte_data_i};
   assign xfer    = byte_valid_i && byte_ready_o;
   assign idx_nxt = idx + 1'b1;
   assign busy    = (state == HDR) || (state == LOAD) || (state == CHK);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= HDR;
         bcnt         <= '0;
         part         <= '0;
         n            <= '0;
         idx          <= '0;
         csum         <= '0;
         byte_ready_o <= 1'b0;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= '0;
         imem_data_o  <= '0;
         cpu_run_o    <= 1'b0;
         load_err_o   <= 1'b0;
      end else begin
         imem_we_o    <= 1'b0;
         byte_ready_o <= busy;
         // start wins over a simultaneous byte, which is dropped
         if (start_i) begin
            state        <= HDR;
            bcnt         <= '0;
            part         <= '0;
            idx          <= '0;
            csum         <= '0;
            cpu_run_o    <= 1'b0;
            load_err_o   <= 1'b0;
            byte_ready_o <= 1'b1;
         end else if (xfer) begin
            bcnt <= bcnt + 2'd1;
            part <= w[23:0];
            if (bcnt == 2'd3) begin
               case (state)
                  HDR: begin
                     if (w == 32'd0) begin
                        csum  <= '0;
                        state <= CHK;
                     end else if (w > 32'(MAX_WORDS)) begin
                        state        <= ERR;
                        load_err_o   <= 1'b1;
                        byte_ready_o <= 1'b0;
                     end else begin
                        n     <= w[ADDR_W:0];
                        idx   <= '0;
                        csum  <= '0;
                        state <= LOAD;
                     end
                  end
                  LOAD: begin
                     imem_we_o   <= 1'b1;
                     imem_addr_o <= 32'({idx, 2'b00});
                     imem_data_o <= w;
                     csum        <= csum ^ w;
                     idx         <= idx_nxt;
                     if (idx_nxt == n) state <= CHK;
                  end
                  CHK: begin
                     state        <= (w == csum) ? DONE : ERR;
                     cpu_run_o    <= (w == csum);
                     load_err_o   <= (w != csum);
                     byte_ready_o <= 1'b0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a list-based load model.
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic        imem_we_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_o;
   logic        cpu_run_o;
   logic        load_err_o;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [63:0] wr_q[$];
   logic [31:0] pay[0:255];

   imem_loader #(.ADDR_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
      .cpu_run_o(cpu_run_o), .load_err_o(load_err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (imem_we_o) wr_q.push_back({imem_addr_o, imem_data_o});

   initial begin
      #3000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task send_byte(input logic [7:0] b, input int gap);
      int t;
      for (int i = 0; i < gap; i++) begin
         byte_valid_i = 1'b0;
         @(negedge clk);
      end
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      t = 0;
      while (!byte_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task send_word(input logic [31:0] v, input int gapmax);
      for (int i = 0; i < 4; i++) send_byte(v[31-8*i -: 8], int'($urandom_range(gapmax, 0)));
   endtask

   task do_start();
      byte_valid_i = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("start_run", {31'd0, cpu_run_o}, 32'd0);
      chk("start_err", {31'd0, load_err_o}, 32'd0);
      chk("start_ready", {31'd0, byte_ready_o}, 32'd1);
   endtask

   task run(input logic [31:0] n, input logic [31:0] cs, input int gapmax, input bit skip_start);
      int base;
      int c0;
      int bad;
      logic [31:0] x;
      logic exp_done;
      if (!skip_start) do_start();
      base = wr_q.size();
      c0 = cyc;
      send_word(n, gapmax);
      if (n > 32'd256) begin
         byte_valid_i = 1'b0;
         chk($sformatf("n%0d_err", n), {31'd0, load_err_o}, 32'd1);
         chk($sformatf("n%0d_run", n), {31'd0, cpu_run_o}, 32'd0);
         chk($sformatf("n%0d_ready", n), {31'd0, byte_ready_o}, 32'd0);
         repeat (3) @(negedge clk);
         chk($sformatf("n%0d_nwr", n), 32'(wr_q.size() - base), 32'd0);
         return;
      end
      x = 32'd0;
      for (int i = 0; i < int'(n); i++) begin
         send_word(pay[i], gapmax);
         x ^= pay[i];
      end
      send_word(cs, gapmax);
      byte_valid_i = 1'b0;
      exp_done = (x == cs);
      chk($sformatf("n%0d_run", n), {31'd0, cpu_run_o}, {31'd0, exp_done});
      chk($sformatf("n%0d_err", n), {31'd0, load_err_o}, {31'd0, !exp_done});
      chk($sformatf("n%0d_ready", n), {31'd0, byte_ready_o}, 32'd0);
      if (gapmax == 0) chk($sformatf("n%0d_cycles", n), 32'(cyc - c0), 4 * (n + 2));
      repeat (2) @(negedge clk);
      chk($sformatf("n%0d_hold", n), {30'd0, cpu_run_o, load_err_o}, {30'd0, exp_done, !exp_done});
      chk($sformatf("n%0d_nwr", n), 32'(wr_q.size() - base), n);
      bad = 0;
      for (int i = 0; i < int'(n) && base + i < wr_q.size(); i++)
         if (wr_q[base+i] !== {32'(i * 4), pay[i]}) bad++;
      chk($sformatf("n%0d_wrdata", n), 32'(bad), 32'd0);
   endtask

   function automatic logic [31:0] xor_of(input int n);
      logic [31:0] x = 32'd0;
      for (int i = 0; i < n; i++) x ^= pay[i];
      return x;
   endfunction

   initial begin
      int base;
      logic [31:0] cs;
      rst = 1'b1;
      start_i = 1'b0;
      byte_valid_i = 1'b0;
      byte_data_i = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_outs", {26'd0, byte_ready_o, imem_we_o, cpu_run_o, load_err_o, |imem_addr_o, |imem_data_o}, 32'd0);
      rst = 1'b0;
      #1 chk("rst_rel_ready0", {31'd0, byte_ready_o}, 32'd0);
      @(negedge clk);
      chk("rst_rel_ready1", {31'd0, byte_ready_o}, 32'd1);

      pay[0] = 32'h20010005;
      pay[1] = 32'h20020007;
      run(2, 32'h00030002, 0, 1'b1);
      chk("normal_wr0", wr_q[0][63:32], 32'h0);
      chk("normal_wr1", wr_q[1][31:0], 32'h20020007);
      run(2, 32'h00030003, 0, 1'b0);
      run(2, 32'h00030002, 0, 1'b0);

      run(0, 32'h0, 0, 1'b0);
      run(0, 32'h1, 0, 1'b0);
      run(257, 32'h0, 0, 1'b0);

      for (int i = 0; i < 256; i++) pay[i] = $urandom;
      run(256, xor_of(256), 0, 1'b0);
      chk("n256_last_addr", wr_q[wr_q.size()-1][63:32], 32'h3FC);

      for (int i = 0; i < 3; i++) pay[i] = $urandom;
      run(3, xor_of(3), 0, 1'b0);
      run(3, xor_of(3), 3, 1'b0);
      run(3, xor_of(3) ^ 32'h100, 2, 1'b0);

      for (int k = 0; k < 6; k++) begin
         int nn;
         nn = int'($urandom_range(8, 1));
         for (int i = 0; i < nn; i++) pay[i] = $urandom;
         cs = xor_of(nn) ^ (($urandom_range(1, 0) == 1) ? (32'd1 << $urandom_range(31, 0)) : 32'd0);
         run(32'(nn), cs, int'($urandom_range(2, 0)), 1'b0);
      end

      // abort mid-word with a byte offered on the same edge as start
      pay[0] = $urandom;
      pay[1] = $urandom;
      do_start();
      base = wr_q.size();
      send_word(2, 0);
      send_word(pay[0], 0);
      send_byte(pay[1][31:24], 0);
      send_byte(pay[1][23:16], 0);
      start_i = 1'b1;
      byte_valid_i = 1'b1;
      byte_data_i = 8'hAA;
      @(negedge clk);
      start_i = 1'b0;
      byte_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_nwr", 32'(wr_q.size() - base), 32'd1);
      chk("abort_ready", {31'd0, byte_ready_o}, 32'd1);
      pay[0] = $urandom;
      run(1, pay[0], 0, 1'b1);

      // asynchronous reset in the middle of a payload word
      pay[0] = $urandom;
      do_start();
      base = wr_q.size();
      send_word(1, 0);
      send_byte(pay[0][31:24], 0);
      send_byte(pay[0][23:16], 0);
      #2 rst = 1'b1;
      #1 chk("amid_rst_outs", {26'd0, byte_ready_o, imem_we_o, cpu_run_o, load_err_o, |imem_addr_o, |imem_data_o}, 32'd0);
      @(negedge clk);
      byte_valid_i = 1'b0;
      rst = 1'b0;
      #1 chk("amid_rel_ready0", {31'd0, byte_ready_o}, 32'd0);
      @(negedge clk);
      chk("amid_rel_ready1", {31'd0, byte_ready_o}, 32'd1);
      chk("amid_nwr", 32'(wr_q.size() - base), 32'd0);
      run(1, pay[0], 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
